resp_misr_compactor: RTL and testbench

//  Downstream response compactor for the stdcell gate-level test circuits.
//  - Consumes one response vector per beat from the circuit under test (CUT) and folds it into a MISR signature.
//  - Counts beats; when NUM_PATTERNS beats have been absorbed, presents the final signature and a pass/fail flag against a golden value.
//  - Sits between the CUT output bus and the test controller.

---
 rtl/misr_pkg.sv | 32 +++
 rtl/misr_core.sv | 32 +++
 rtl/resp_misr_compactor.sv | 113 +++++++++++
 tb/tb_resp_misr_compactor.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/misr_pkg.sv
// Shared types and helpers for the MISR response compactor: FSM state encoding,
// the default 43-bit feedback polynomial and a width-generic Galois MISR step.
package misr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } misr_state_t;

  // Widest signature the step helper supports; cores zero-extend into this.
  localparam int MISR_MAX_W = 64;

  // x^43 + x^6 + x^4 + x^3 + 1 : feedback taps into stages 6, 4, 3 and 0.
  localparam logic [42:0] POLY_43 = 43'h000_0000_0059;

  // One Galois MISR update on the low `width` bits; upper bits stay zero.
  function automatic logic [MISR_MAX_W-1:0] misr_step(
    input logic [MISR_MAX_W-1:0] sig,
    input logic [MISR_MAX_W-1:0] data,
    input logic [MISR_MAX_W-1:0] poly,
    input int                    width
  );
    logic [MISR_MAX_W-1:0] mask;
    logic [MISR_MAX_W-1:0] shifted;
    mask    = (width >= MISR_MAX_W) ? '1
            : ((MISR_MAX_W'(1) << width) - MISR_MAX_W'(1));
    shifted = (sig << 1) & mask;
    return shifted ^ (sig[width-1] ? (poly & mask) : '0) ^ (data & mask);
  endfunction

endpackage

// File: rtl/misr_core.sv
// MISR signature register with synchronous seed load and per-beat update enable.
// sig_next is exported so the caller can compare the post-update value on the same edge.
module misr_core
  import misr_pkg::*;
#(
  parameter int               WIDTH = 43,
  parameter logic [WIDTH-1:0] POLY  = POLY_43,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] sig,
  output logic [WIDTH-1:0] sig_next
);

  // WIDTH must not exceed MISR_MAX_W; the step helper works on that fixed width.
  always_comb begin
    sig_next = WIDTH'(misr_step(MISR_MAX_W'(sig), MISR_MAX_W'(data_in),
                                MISR_MAX_W'(POLY), WIDTH));
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sig <= SEED;
    end else if (en) begin
      sig <= sig_next;
    end
  end

endmodule

// File: rtl/resp_misr_compactor.sv
// Response compactor: folds NUM_PATTERNS CUT response beats into a MISR signature
// and flags pass/fail against golden_sig. Define RESP_XMASK_EN to add resp_xmask.
module resp_misr_compactor
  import misr_pkg::*;
#(
  parameter int               WIDTH        = 43,
  parameter int               NUM_PATTERNS = 512,
  parameter logic [WIDTH-1:0] POLY         = POLY_43,
  parameter logic [WIDTH-1:0] SEED         = '0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                abort,
  input  logic                                resp_valid,
  output logic                                resp_ready,
  input  logic [WIDTH-1:0]                    resp_data,
`ifdef RESP_XMASK_EN
  input  logic [WIDTH-1:0]                    resp_xmask,
`endif
  input  logic [WIDTH-1:0]                    golden_sig,
  output logic                                busy,
  output logic                                done,
  output logic                                pass,
  output logic [WIDTH-1:0]                    signature,
  output logic [$clog2(NUM_PATTERNS+1)-1:0]   beat_cnt
);

  localparam int               CNT_W    = $clog2(NUM_PATTERNS + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS);

  misr_state_t      state;
  logic             accept;
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] sig_next;
  logic [CNT_W-1:0] cnt_inc;

`ifdef RESP_XMASK_EN
  assign data_in = resp_data & ~resp_xmask;
`else
  assign data_in = resp_data;
`endif

  // Abort outranks everything, including a beat offered on the same edge.
  assign accept  = resp_valid && resp_ready && !abort;
  assign load    = rst || (start && !abort && (state != RUN));
  assign cnt_inc = (beat_cnt == LAST_CNT) ? beat_cnt : beat_cnt + CNT_W'(1);

  misr_core #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr_core (
    .clk      (clk),
    .load     (load),
    .en       (accept),
    .data_in  (data_in),
    .sig      (signature),
    .sig_next (sig_next)
  );

  // resp_ready/busy/done/pass are registered alongside the state they decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      resp_ready <= 1'b0;
    end else if (abort) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      resp_ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state      <= RUN;
            beat_cnt   <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            resp_ready <= 1'b1;
          end
        end
        RUN: begin
          if (accept) begin
            beat_cnt <= cnt_inc;
            if (cnt_inc == LAST_CNT) begin
              state      <= DONE;
              busy       <= 1'b0;
              done       <= 1'b1;
              resp_ready <= 1'b0;
              pass       <= (sig_next == golden_sig);
            end
          end
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          pass       <= 1'b0;
          resp_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_resp_misr_compactor.sv
// Scoreboard bench for resp_misr_compactor: small 4-bit instances for the directed
// cases plus a default 43-bit / 512-beat instance checked against a reference MISR.
module tb_resp_misr_compactor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, abort = 1'b0, vld = 1'b0;
  logic        start1 = 1'b0, start2 = 1'b0, start3 = 1'b0, startd = 1'b0;
  logic [3:0]  data4 = '0, gold4 = '0, xmask4 = '0;
  logic [42:0] data43 = '0, gold43 = '0, xmask43 = '0;

  logic        rdy1, busy1, done1, pass1;
  logic        rdy2, busy2, done2, pass2;
  logic        rdy3, busy3, done3, pass3;
  logic        rdyd, busyd, doned, passd;
  logic [3:0]  sig1, sig2, sig3;
  logic [42:0] sigd;
  logic [0:0]  cnt1;
  logic [1:0]  cnt2, cnt3;
  logic [9:0]  cntd;

  int checks = 0;
  int passed = 0;
  logic [3:0]  exp_q[$];
  logic [42:0] expd_q[$];

  resp_misr_compactor #(.WIDTH(4), .NUM_PATTERNS(1), .POLY(4'b0011), .SEED(4'h0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort), .resp_valid(vld), .resp_ready(rdy1),
    .resp_data(data4),
`ifdef RESP_XMASK_EN
    .resp_xmask(xmask4),
`endif
    .golden_sig(gold4), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1), .beat_cnt(cnt1));

  resp_misr_compactor #(.WIDTH(4), .NUM_PATTERNS(2), .POLY(4'b0011), .SEED(4'h0)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort), .resp_valid(vld), .resp_ready(rdy2),
    .resp_data(data4),
`ifdef RESP_XMASK_EN
    .resp_xmask(xmask4),
`endif
    .golden_sig(gold4), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2), .beat_cnt(cnt2));

  resp_misr_compactor #(.WIDTH(4), .NUM_PATTERNS(3), .POLY(4'b0011), .SEED(4'h0)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(abort), .resp_valid(vld), .resp_ready(rdy3),
    .resp_data(data4),
`ifdef RESP_XMASK_EN
    .resp_xmask(xmask4),
`endif
    .golden_sig(gold4), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3), .beat_cnt(cnt3));

  resp_misr_compactor u_dutd (
    .clk(clk), .rst(rst), .start(startd), .abort(abort), .resp_valid(vld), .resp_ready(rdyd),
    .resp_data(data43),
`ifdef RESP_XMASK_EN
    .resp_xmask(xmask43),
`endif
    .golden_sig(gold43), .busy(busyd), .done(doned), .pass(passd), .signature(sigd), .beat_cnt(cntd));

  function automatic logic [3:0] model4(input logic [3:0] s, input logic [3:0] d);
    return {s[2:0], 1'b0} ^ (s[3] ? 4'b0011 : 4'b0000) ^ d;
  endfunction

  // x^43 + x^6 + x^4 + x^3 + 1
  function automatic logic [42:0] model43(input logic [42:0] s, input logic [42:0] d);
    return {s[41:0], 1'b0} ^ (s[42] ? 43'h59 : 43'h0) ^ d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    vld = 1'b0; abort = 1'b1; tick(); abort = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (sig2 !== 4'h0) $display("FAIL reset_sig got %h want 0", sig2); else passed++;
    checks++; if (cnt2 !== 2'd0) $display("FAIL reset_cnt got %0d want 0", cnt2); else passed++;
    checks++; if ({busy2, done2, pass2, rdy2} !== 4'b0000)
      $display("FAIL reset_flags got %b want 0000", {busy2, done2, pass2, rdy2}); else passed++;
    checks++; if ({sigd, cntd, busyd, doned, passd, rdyd} !== '0)
      $display("FAIL reset_default got %h/%0d want 0", sigd, cntd); else passed++;
  endtask

  task automatic test_two_beat(input logic [3:0] g, input logic exp_pass);
    logic [3:0] s, e;
    s = 4'h0; gold4 = g;
    start2 = 1'b1; tick(); start2 = 1'b0;
    checks++; if ({busy2, done2, pass2, rdy2, cnt2} !== 6'b1001_00)
      $display("FAIL run_entry got %b/%0d want 1001/0", {busy2, done2, pass2, rdy2}, cnt2); else passed++;
    vld = 1'b1; data4 = 4'h8; s = model4(s, data4); exp_q.push_back(s); tick();
    e = exp_q.pop_front();
    checks++; if (sig2 !== e || cnt2 !== 2'd1)
      $display("FAIL beat1_sig got %h/%0d want %h/1", sig2, cnt2, e); else passed++;
    data4 = 4'h1; s = model4(s, data4); exp_q.push_back(s); tick(); vld = 1'b0;
    e = exp_q.pop_front();
    checks++; if (sig2 !== e) $display("FAIL beat2_sig got %h want %h", sig2, e); else passed++;
    checks++; if ({busy2, done2, pass2, rdy2} !== {1'b0, 1'b1, exp_pass, 1'b0})
      $display("FAIL done_flags got %b want %b", {busy2, done2, pass2, rdy2}, {1'b0, 1'b1, exp_pass, 1'b0});
    else passed++;
    checks++; if (cnt2 !== 2'd2) $display("FAIL done_cnt got %0d want 2", cnt2); else passed++;
    gold4 = ~g; tick();
    checks++; if (pass2 !== exp_pass || done2 !== 1'b1)
      $display("FAIL pass_hold got %b want %b", pass2, exp_pass); else passed++;
    go_idle();
  endtask

  task automatic test_abort();
    logic [3:0] e;
    start3 = 1'b1; tick(); start3 = 1'b0;
    vld = 1'b1; data4 = 4'h5; exp_q.push_back(model4(4'h0, 4'h5)); tick();
    data4 = 4'h7; abort = 1'b1; tick(); abort = 1'b0;
    e = exp_q.pop_front();
    checks++; if ({busy3, done3, rdy3} !== 3'b000 || cnt3 !== 2'd1 || sig3 !== e)
      $display("FAIL abort_state got %b/%0d/%h want 000/1/%h", {busy3, done3, rdy3}, cnt3, sig3, e);
    else passed++;
    tick();
    checks++; if (cnt3 !== 2'd1 || sig3 !== e)
      $display("FAIL abort_ignore got %0d/%h want 1/%h", cnt3, sig3, e); else passed++;
    vld = 1'b0; start3 = 1'b1; abort = 1'b1; tick(); start3 = 1'b0; abort = 1'b0;
    checks++; if (busy3 !== 1'b0 || rdy3 !== 1'b0)
      $display("FAIL start_abort got %b%b want 00", busy3, rdy3); else passed++;
  endtask

  task automatic test_last_abort();
    start2 = 1'b1; tick(); start2 = 1'b0;
    vld = 1'b1; data4 = 4'h2; tick();
    data4 = 4'h4; abort = 1'b1; tick(); abort = 1'b0; vld = 1'b0;
    checks++; if ({busy2, done2, pass2, rdy2} !== 4'b0000 || cnt2 !== 2'd1 || sig2 !== 4'h2)
      $display("FAIL last_abort got %b/%0d/%h want 0000/1/2", {busy2, done2, pass2, rdy2}, cnt2, sig2);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] s, e;
    s = 4'h0;
    start2 = 1'b1; tick(); start2 = 1'b0;
    vld = 1'b1; data4 = 4'h3; s = model4(s, data4); exp_q.push_back(s); tick();
    e = exp_q.pop_front();
    checks++; if (sig2 !== e) $display("FAIL toggle_b1 got %h want %h", sig2, e); else passed++;
    vld = 1'b0; data4 = 4'hF; start2 = 1'b1; tick(); start2 = 1'b0;
    checks++; if (cnt2 !== 2'd1 || busy2 !== 1'b1 || sig2 !== e)
      $display("FAIL toggle_gap got %0d/%b/%h want 1/1/%h", cnt2, busy2, sig2, e); else passed++;
    vld = 1'b1; data4 = 4'h6; s = model4(s, data4); exp_q.push_back(s); tick(); vld = 1'b0;
    e = exp_q.pop_front();
    checks++; if (sig2 !== e || cnt2 !== 2'd2 || done2 !== 1'b1)
      $display("FAIL toggle_done got %h/%0d/%b want %h/2/1", sig2, cnt2, done2, e); else passed++;
    tick();
    checks++; if (cnt2 !== 2'd2 || done2 !== 1'b1)
      $display("FAIL done_stable got %0d/%b want 2/1", cnt2, done2); else passed++;
    data4 = 4'hA; start2 = 1'b1; tick(); start2 = 1'b0;
    checks++; if (sig2 !== 4'h0 || cnt2 !== 2'd0 || {busy2, done2, pass2, rdy2} !== 4'b1001)
      $display("FAIL restart got %h/%0d/%b want 0/0/1001", sig2, cnt2, {busy2, done2, pass2, rdy2});
    else passed++;
    go_idle();
  endtask

  task automatic test_rst_mid_run();
    start2 = 1'b1; tick(); start2 = 1'b0;
    vld = 1'b1; data4 = 4'h9; tick();
    rst = 1'b1; tick(); rst = 1'b0; vld = 1'b0;
    checks++; if (sig2 !== 4'h0 || cnt2 !== 2'd0 || {busy2, done2, pass2, rdy2} !== 4'b0000)
      $display("FAIL rst_mid got %h/%0d/%b want 0/0/0000", sig2, cnt2, {busy2, done2, pass2, rdy2});
    else passed++;
  endtask

  task automatic test_single_pattern();
    logic [3:0] e;
    gold4 = 4'h5;
    start1 = 1'b1; tick(); start1 = 1'b0;
    vld = 1'b1; data4 = 4'h5; exp_q.push_back(model4(4'h0, 4'h5)); tick(); vld = 1'b0;
    e = exp_q.pop_front();
    checks++; if (sig1 !== e || cnt1 !== 1'b1 || {busy1, done1, pass1, rdy1} !== 4'b0110)
      $display("FAIL np1 got %h/%0d/%b want %h/1/0110", sig1, cnt1, {busy1, done1, pass1, rdy1}, e);
    else passed++;
    go_idle();
  endtask

`ifdef RESP_XMASK_EN
  task automatic test_xmask();
    logic [3:0] s, e;
    s = 4'h0; xmask4 = 4'h8; gold4 = 4'h1;
    start2 = 1'b1; tick(); start2 = 1'b0;
    vld = 1'b1; data4 = 4'h8; s = model4(s, data4 & ~xmask4); exp_q.push_back(s); tick();
    data4 = 4'h1; s = model4(s, data4 & ~xmask4); exp_q.push_back(s); tick(); vld = 1'b0;
    void'(exp_q.pop_front());
    e = exp_q.pop_front();
    checks++; if (sig2 !== e || sig2 !== 4'h1 || pass2 !== 1'b1)
      $display("FAIL xmask got %h/%b want %h/1", sig2, pass2, e); else passed++;
    xmask4 = 4'h0;
    go_idle();
  endtask
`endif

  task automatic test_default_run();
    logic [42:0] vec[512];
    logic [42:0] s, e;
    int errs;
    s = '0; errs = 0;
    for (int i = 0; i < 512; i++) begin
      vec[i] = 43'({$urandom(), $urandom()});
      s = model43(s, vec[i]);
    end
    gold43 = s; s = '0;
    startd = 1'b1; tick(); startd = 1'b0;
    for (int i = 0; i < 512; i++) begin
      if (i % 37 == 5) begin
        vld = 1'b0; data43 = ~vec[i]; tick();
      end
      vld = 1'b1; data43 = vec[i]; s = model43(s, vec[i]); expd_q.push_back(s); tick();
      e = expd_q.pop_front();
      checks++;
      if (sigd !== e || cntd !== 10'(i + 1)) begin
        if (errs < 5) $display("FAIL dflt_beat%0d got %h/%0d want %h/%0d", i, sigd, cntd, e, i + 1);
        errs++;
      end else passed++;
    end
    vld = 1'b0;
    checks++; if (doned !== 1'b1 || passd !== 1'b1 || busyd !== 1'b0 || cntd !== 10'd512 || sigd !== gold43)
      $display("FAIL dflt_final got %b%b%b/%0d/%h want 110/512/%h", doned, passd, busyd, cntd, sigd, gold43);
    else passed++;
    go_idle();
  endtask

  initial begin
    test_reset();
    test_two_beat(4'h2, 1'b1);
    test_two_beat(4'h3, 1'b0);
    test_abort();
    test_last_abort();
    test_back_to_back();
    test_rst_mid_run();
    test_single_pattern();
`ifdef RESP_XMASK_EN
    test_xmask();
`endif
    test_default_run();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
